aes_key_sched_iter: RTL and testbench
=====================================

# aes_key_sched_iter

Iterative, area-reduced AES key-schedule generator. It is the parametrised successor of the unrolled 128-bit expander and supports 128- and 256-bit keys. It takes a cipher key through a valid/ready handshake and streams the round keys rk0..rkNR, one 128-bit key per handshake, reusing a single `S4` substitution instance. It sits between the key register file and an iterative round engine; an optional replay buffer serves decryption-order key streams.

## Interface
Parameters:
- `KEY_BITS`, default 128. Key length; legal values are 128 and 256. Any other value is a synthesis-time `$error`.
- `NR`, derived, not overridable. Round count: 10 when `KEY_BITS`=128, 14 when `KEY_BITS`=256.

Ports:
- `clk`  in  1  rising-edge clock, single domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `key_in`  in  `KEY_BITS`  cipher key, MSB = first key byte.
- `key_valid`  in  1  `key_in` is valid.
- `key_ready`  out  1  block is idle and can accept a key.
- `rk_out`  out  128  current round key.
- `rk_idx`  out  4  index of `rk_out`, 0..NR.
- `rk_valid`  out  1  `rk_out`/`rk_idx` are valid.
- `rk_ready`  in  1  consumer accepts the round key.
- `rk_last`  out  1  high with `rk_valid` when the key shown is the last key of the stream.
- `replay`  in  1  request a reverse-order replay; sampled only in IDLE.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, OUT, SBOX, REPLAY.
- IDLE: `key_ready`=1.
  - On `key_valid`&&`key_ready`: latch the key into the word window w[0..NK-1] (NK=4 or 8), set rcon=8'h01, idx=0, go to OUT.
  - `replay` (macro only, see Configuration): go to REPLAY.
  - If `key_valid` and `replay` are both high, the key wins.
- OUT: `rk_valid`=1, `rk_out` = window words w[0..3] for the current idx.
  - On handshake, if idx==NR: go to IDLE.
  - If `KEY_BITS`=256 and idx==0: rk1 = w[4..7] already exists, so shift the window and stay in OUT with idx=1.
  - Otherwise: drive `S4` and go to SBOX.
- `S4` input for the next key:
  - Start of a full key period (always when NK=4; even new idx when NK=8): RotWord(w[last]).
  - Odd new idx when NK=8: w[last] without rotation (SubWord only).
- SBOX: one cycle waiting on the registered `S4` output t.
  - If rotation was applied: t ^= {rcon,24'h0}, then rcon = xtime(rcon), i.e. {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1b : 8'h00).
  - New words n0 = w[j]^t, n1 = n0^w[j+1], n2 = n1^w[j+2], n3 = n2^w[j+3], where j = first word of the window period.
  - Shift the window, idx++, go to OUT.
- rcon sequences:
  - 128-bit: 01,02,04,08,10,20,40,80,1b,36.
  - 256-bit: 01,02,04,08,10,20,40.
- `rk_last` = (idx==NR) in forward mode; (idx==0) in REPLAY.
- `rk_out`/`rk_idx` hold stable while `rk_valid` && !`rk_ready`.

## Timing
- Reset values: `key_ready`=1, `rk_valid`=0, `rk_last`=0, `busy`=0, `rk_out`=0, `rk_idx`=0, state=IDLE, rcon=8'h01, replay buffer contents not reset.
- Key accepted at edge T: rk0 valid in cycle T+1.
- rk(k) accepted at edge t:
  - rk(k+1) valid at t+2 (one SBOX cycle).
  - Exception: 256-bit rk1 is valid at t+1.
- Minimum stream length with `rk_ready` held at 1:
  - 128-bit: 1+2·10 = 21 cycles.
  - 256-bit: 1+1+2·13 = 28 cycles.
- `key_ready` returns to 1 in the cycle after the last handshake.
- `rst_n` low mid-stream: asynchronous return to IDLE, `rk_valid` drops immediately, the partial stream is discarded, and no key is pending after release.

## Configuration
- `AES_KS_REPLAY_EN`
  - Defined: an (NR+1)×128 register buffer captures every rk on its forward handshake. `replay` in IDLE, provided a full forward stream has completed since reset, streams rkNR..rk0 from the buffer. In that mode one key is valid per cycle under `rk_ready`, there are no SBOX cycles, and `rk_last` is high at idx 0. If no complete stream exists, `replay` is ignored.
  - Undefined: no buffer, `replay` is ignored, and the REPLAY state is absent.

## Test plan
- 128-bit, key 2b7e151628aed2a6abf7158809cf4f3c, `rk_ready`=1 -> rk1=a0fafe1788542cb123a339392a6c7605, rk10=d014f9a8c9ee2589e13f0cc8b6630ca6, `rk_last` only with rk10, 21 cycles total.
- 256-bit, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> rk1=1f352c073b6108d72d9810a30914dff4, rk2=9ba354118e6925afa51a8b5f2067fcde, rk14=fe4890d1e6188d0b046df344706c631e.
- Random `rk_ready` backpressure (30% low) on the 128-bit vector -> identical key sequence, `rk_out` stable while stalled, no skipped or duplicated idx.
- `key_valid` pulsed while `busy` -> `key_ready`=0 and the key is ignored; `rst_n` asserted at rk5 -> `rk_valid`=0 asynchronously, and a new key after release restarts at rk0 with rcon 01.
- `AES_KS_REPLAY_EN` builds: replay after the 128-bit stream -> d014f9a8…, …, 2b7e1516… in 11 consecutive cycles, `rk_last` at idx 0. Replay directly after reset -> no `rk_valid`.

Source files
------------

// File: rtl/aes_key_sched_iter_if.sv
// aes_key_sched_iter_if: cipher-key input and round-key output handshake bundle.
interface aes_key_sched_iter_if #(
    parameter int KEY_BITS = 128
);
    logic [KEY_BITS-1:0] key_in;
    logic                key_valid;
    logic                key_ready;
    logic [127:0]        rk_out;
    logic [3:0]          rk_idx;
    logic                rk_valid;
    logic                rk_ready;
    logic                rk_last;
    logic                replay;
    logic                busy;
    modport master (
        output key_in, key_valid, rk_ready, replay,
        input  key_ready, rk_out, rk_idx, rk_valid, rk_last, busy
    );
    modport slave (
        input  key_in, key_valid, rk_ready, replay,
        output key_ready, rk_out, rk_idx, rk_valid, rk_last, busy
    );
endinterface

// File: rtl/aes_key_sched_iter.sv
// aes_key_sched_iter: iterative AES-128/256 key schedule, one shared SubWord per step.
// Define AES_KS_REPLAY_EN to add the reverse-order replay buffer and REPLAY state.
module aes_key_sched_iter #(
    parameter int KEY_BITS = 128
) (
    input logic clk,
    input logic rst_n,
    aes_key_sched_iter_if.slave ks
);
    localparam int NK = KEY_BITS / 32;
    localparam logic [3:0] NR = (KEY_BITS == 256) ? 4'd14 : 4'd10;

    if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_key_sched_iter: KEY_BITS must be 128 or 256");
    end

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ x : p;
            x = xt(x);
        end
        return p;
    endfunction

    // Inverse as a^254 (0 maps to 0), then the AES affine transform
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] a2, a3, a12, a15, a240, s;
        a2   = gmul(a, a);
        a3   = gmul(a2, a);
        a12  = gmul(gmul(a3, a3), gmul(a3, a3));
        a15  = gmul(a12, a3);
        a240 = gmul(a15, a15);
        a240 = gmul(a240, a240);
        a240 = gmul(a240, a240);
        a240 = gmul(a240, a240);
        s    = gmul(gmul(a240, a12), a2);
        return s ^ {s[6:0], s[7]} ^ {s[5:0], s[7:6]} ^ {s[4:0], s[7:5]} ^ {s[3:0], s[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

`ifdef AES_KS_REPLAY_EN
    typedef enum logic [1:0] {IDLE, OUT, SBOX, REPLAY} state_t;
`else
    typedef enum logic [1:0] {IDLE, OUT, SBOX} state_t;
`endif

    state_t              state_q;
    logic [KEY_BITS-1:0] w_q;
    logic [31:0]         t_q;
    logic                rot_q;
    logic [7:0]          rcon_q;
    logic [127:0]        rk_q;
    logic [3:0]          idx_q;
    logic                valid_q, last_q, ready_q, busy_q;

    // Window word 0 sits at the MSB; the shown key is always words 0..3
    logic [31:0]         last_w, s4_in, tx, n0, n1, n2, n3;
    logic                rot_d;
    logic [KEY_BITS-1:0] nw_d, sw_d;

    assign last_w = w_q[KEY_BITS-97 -: 32];
    assign rot_d  = (NK == 4) || idx_q[0];
    assign s4_in  = rot_d ? {last_w[23:0], last_w[31:24]} : last_w;
    assign tx     = rot_q ? t_q ^ {rcon_q, 24'h0} : t_q;
    assign n0     = w_q[127:96] ^ tx;
    assign n1     = n0 ^ w_q[95:64];
    assign n2     = n1 ^ w_q[63:32];
    assign n3     = n2 ^ w_q[31:0];

    // For 256-bit keys the window holds {newest key, previous key}
    if (NK == 8) begin : g_w8
        assign nw_d = {n0, n1, n2, n3, w_q[KEY_BITS-1 -: 128]};
        assign sw_d = {w_q[127:0], w_q[KEY_BITS-1 -: 128]};
    end else begin : g_w4
        assign nw_d = {n0, n1, n2, n3};
        assign sw_d = w_q;
    end

`ifdef AES_KS_REPLAY_EN
    logic [127:0] buf_q [0:NR];
    logic         full_q;

    always_ff @(posedge clk) begin
        if (state_q == OUT && ks.rk_ready) buf_q[idx_q] <= rk_q;
    end
`else
    logic unused_replay;
    assign unused_replay = ks.replay;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            w_q     <= '0;
            t_q     <= '0;
            rot_q   <= 1'b0;
            rcon_q  <= 8'h01;
            rk_q    <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
`ifdef AES_KS_REPLAY_EN
            full_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (ks.key_valid) begin
                        w_q     <= ks.key_in;
                        rcon_q  <= 8'h01;
                        idx_q   <= '0;
                        rk_q    <= ks.key_in[KEY_BITS-1 -: 128];
                        valid_q <= 1'b1;
                        last_q  <= 1'b0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= OUT;
`ifdef AES_KS_REPLAY_EN
                        full_q  <= 1'b0;
                    end else if (ks.replay && full_q) begin
                        rk_q    <= buf_q[NR];
                        idx_q   <= NR;
                        valid_q <= 1'b1;
                        last_q  <= 1'b0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= REPLAY;
`endif
                    end
                end
                OUT: begin
                    if (ks.rk_ready) begin
                        if (idx_q == NR) begin
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
`ifdef AES_KS_REPLAY_EN
                            full_q  <= 1'b1;
`endif
                        end else if (NK == 8 && idx_q == 4'd0) begin
                            w_q   <= sw_d;
                            rk_q  <= sw_d[KEY_BITS-1 -: 128];
                            idx_q <= 4'd1;
                        end else begin
                            t_q     <= sub_word(s4_in);
                            rot_q   <= rot_d;
                            valid_q <= 1'b0;
                            state_q <= SBOX;
                        end
                    end
                end
                SBOX: begin
                    w_q     <= nw_d;
                    rk_q    <= nw_d[KEY_BITS-1 -: 128];
                    idx_q   <= idx_q + 4'd1;
                    valid_q <= 1'b1;
                    last_q  <= (idx_q + 4'd1 == NR);
                    rcon_q  <= rot_q ? xt(rcon_q) : rcon_q;
                    state_q <= OUT;
                end
`ifdef AES_KS_REPLAY_EN
                REPLAY: begin
                    if (ks.rk_ready) begin
                        if (idx_q == 4'd0) begin
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            rk_q   <= buf_q[idx_q - 4'd1];
                            idx_q  <= idx_q - 4'd1;
                            last_q <= (idx_q == 4'd1);
                        end
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ks.key_ready = ready_q;
    assign ks.rk_out    = rk_q;
    assign ks.rk_idx    = idx_q;
    assign ks.rk_valid  = valid_q;
    assign ks.rk_last   = last_q;
    assign ks.busy      = busy_q;
endmodule

// File: tb/tb_aes_key_sched_iter.sv
// tb_aes_key_sched_iter: directed FIPS-197 vectors for 128- and 256-bit key schedules.
module tb_aes_key_sched_iter;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         sel = 1'b0;
    logic         kv = 1'b0;
    logic         rdy = 1'b0;
    logic         rp = 1'b0;
    logic [255:0] kin = '0;
    int           total = 0;
    int           bad = 0;
    int           cyc;
    logic [127:0] got [0:15];

    logic [127:0] e128 [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };
    logic [255:0] k128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    logic [255:0] k256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    always #5 clk = ~clk;

    aes_key_sched_iter_if #(.KEY_BITS(128)) ia ();
    aes_key_sched_iter_if #(.KEY_BITS(256)) ib ();

    aes_key_sched_iter #(.KEY_BITS(128)) u_a (.clk(clk), .rst_n(rst_n), .ks(ia));
    aes_key_sched_iter #(.KEY_BITS(256)) u_b (.clk(clk), .rst_n(rst_n), .ks(ib));

    assign ia.key_in    = kin[255:128];
    assign ib.key_in    = kin;
    assign ia.key_valid = kv && !sel;
    assign ib.key_valid = kv && sel;
    assign ia.rk_ready  = rdy;
    assign ib.rk_ready  = rdy;
    assign ia.replay    = rp && !sel;
    assign ib.replay    = rp && sel;

    logic         v, lst, kr, bsy;
    logic [3:0]   idx;
    logic [127:0] rk;
    assign v   = sel ? ib.rk_valid : ia.rk_valid;
    assign lst = sel ? ib.rk_last : ia.rk_last;
    assign kr  = sel ? ib.key_ready : ia.key_ready;
    assign bsy = sel ? ib.busy : ia.busy;
    assign idx = sel ? ib.rk_idx : ia.rk_idx;
    assign rk  = sel ? ib.rk_out : ia.rk_out;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic run(input logic s, input logic [255:0] k, input int nr, input int pct,
                       input bit poke, input int abort_at, output int cycles);
        logic [127:0] prk;
        logic [3:0]   pidx;
        bit           stall, done;
        int           n;
        sel = s;
        kin = k;
        rdy = 1'b0;
        cycles = 0;
        check("idle_ready", kr, 1);
        kv = 1'b1;
        @(negedge clk);
        kv = 1'b0;
        n = 0;
        stall = 0;
        done = 0;
        prk = '0;
        pidx = '0;
        for (int c = 0; c < 400 && !done; c++) begin
            if (abort_at >= 0 && v && idx == 4'(abort_at)) begin
                rst_n = 1'b0;
                #1;
                check("abort_valid", v, 0);
                check("abort_busy", bsy, 0);
                check("abort_ready", kr, 1);
                check("abort_idx", idx, 0);
                @(negedge clk);
                rst_n = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    check("post_rst_valid", v, 0);
                end
                return;
            end
            if (poke && c == 2) begin
                kin = ~k;
                kv = 1'b1;
            end
            if (poke && c == 3) begin
                check("busy_key_ready", kr, 0);
                check("busy_busy", bsy, 1);
                kv = 1'b0;
                kin = k;
            end
            if (stall) begin
                check("hold_valid", v, 1);
                check("hold_idx", idx, pidx);
                check("hold_rk", rk, prk);
            end
            rdy = ($urandom_range(99) >= pct);
            if (v && rdy) begin
                check("idx_seq", idx, n);
                check("last_flag", lst, n == nr);
                if (n < 16) got[n] = rk;
                n++;
                done = lst;
            end
            stall = v && !rdy;
            prk = rk;
            pidx = idx;
            cycles++;
            @(negedge clk);
        end
        rdy = 1'b0;
        check("stream_done", done, 1);
        check("stream_len", n, nr + 1);
        check("ready_back", kr, 1);
        check("valid_off", v, 0);
    endtask

    task automatic no_replay(input string tag);
        rp = 1'b1;
        rdy = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check(tag, v, 0);
        end
        rp = 1'b0;
        rdy = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            check("rst_valid", v, 0);
            check("rst_last", lst, 0);
            check("rst_ready", kr, 1);
            check("rst_busy", bsy, 0);
            check("rst_idx", idx, 0);
            check("rst_rk", rk, 0);
        end
        sel = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        no_replay("replay_after_reset");

        run(1'b0, k128, 10, 0, 1'b0, -1, cyc);
        check("cycles128", cyc, 21);
        for (int i = 0; i <= 10; i++) check($sformatf("rk128_%0d", i), got[i], e128[i]);

`ifdef AES_KS_REPLAY_EN
        rp = 1'b1;
        rdy = 1'b1;
        @(negedge clk);
        rp = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            check("rp_valid", v, 1);
            check("rp_idx", idx, 10 - i);
            check("rp_rk", rk, e128[10-i]);
            check("rp_last", lst, i == 10);
            @(negedge clk);
        end
        rdy = 1'b0;
        check("rp_end", v, 0);
        check("rp_ready_back", kr, 1);
`else
        no_replay("replay_disabled");
`endif

        run(1'b1, k256, 14, 0, 1'b0, -1, cyc);
        check("cycles256", cyc, 28);
        check("rk256_0", got[0], 128'h603deb1015ca71be2b73aef0857d7781);
        check("rk256_1", got[1], 128'h1f352c073b6108d72d9810a30914dff4);
        check("rk256_2", got[2], 128'h9ba354118e6925afa51a8b5f2067fcde);
        check("rk256_14", got[14], 128'hfe4890d1e6188d0b046df344706c631e);

        run(1'b0, k128, 10, 30, 1'b1, -1, cyc);
        for (int i = 0; i <= 10; i++) check($sformatf("bp_rk_%0d", i), got[i], e128[i]);

        run(1'b0, k128, 10, 0, 1'b0, 5, cyc);
        run(1'b0, k128, 10, 0, 1'b0, -1, cyc);
        check("restart_rk0", got[0], e128[0]);
        check("restart_rk1", got[1], e128[1]);
        check("restart_rk10", got[10], e128[10]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
